// File: rtl/tick_slot_scheduler_if.sv
// ============================================================================
//  Module      : tick_slot_scheduler_if
//  Description : Requester/config bundle between the requester logic and the
//                tick slot scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_slot_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 32
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             tick;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_term;
   logic             cfg_ready;

   modport master (
      output req, cfg_valid, cfg_term,
      input  grant, tick, count, busy, cfg_ready
   );

   modport slave (
      input  req, cfg_valid, cfg_term,
      output grant, tick, count, busy, cfg_ready
   );
endinterface

`default_nettype wire

// File: rtl/tick_slot_scheduler.sv
// ============================================================================
//  Module      : tick_slot_scheduler
//  Description : Round-robin time-slice owner of the shared periodic tick
//                counter, with a deferred terminal-count config port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_slot_scheduler #(
   parameter int N_REQ        = 4,
   parameter int CNT_W        = 32,
   parameter int DEFAULT_TERM = 21
) (
   input  wire logic         clk,
   input  wire logic         rst,
   tick_slot_scheduler_if.slave bus
);

   localparam int                  c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0]    c_ONE      = N_REQ'(1);
   localparam logic [CNT_W-1:0]    c_DEF_TERM = CNT_W'(DEFAULT_TERM);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             r_state,  w_state_n;
   logic [CNT_W-1:0]   r_count,  w_count_n;
   logic [N_REQ-1:0]   r_grant,  w_grant_n;
   logic [c_IDX_W-1:0] r_idx,    w_idx_n;
   logic [c_IDX_W-1:0] r_ptr,    w_ptr_n;
   logic [CNT_W-1:0]   r_term,   w_term_n;
   logic               r_pend_v, w_pend_v_n;
   logic [CNT_W-1:0]   r_pend_t, w_pend_t_n;

   logic               w_tick;
   logic               w_xfer;
   logic [c_IDX_W-1:0] w_ptr_adv;
   logic [c_IDX_W:0]   w_pick_idle;
   logic [c_IDX_W:0]   w_pick_run;

   // Returns {found, index} of the first set request at or after p, wrapping.
   function automatic logic [c_IDX_W:0] f_pick(input logic [N_REQ-1:0]   r,
                                                input logic [c_IDX_W-1:0] p);
      logic [c_IDX_W:0] res;
      int               j;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = (int'(p) + i) % N_REQ;
         if (r[c_IDX_W'(j)]) res = {1'b1, c_IDX_W'(j)};
      end
      return res;
   endfunction

   assign w_tick      = (r_state == RUN) && (r_count >= r_term);
   assign w_xfer      = bus.cfg_valid && !r_pend_v;
   assign w_ptr_adv   = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
   assign w_pick_idle = f_pick(bus.req, r_ptr);
   assign w_pick_run  = f_pick(bus.req, w_ptr_adv);

   assign bus.tick      = w_tick;
   assign bus.grant     = r_grant;
   assign bus.count     = r_count;
   assign bus.busy      = (r_state == RUN);
   assign bus.cfg_ready = !r_pend_v;

   always_comb begin
      w_state_n  = r_state;
      w_count_n  = r_count;
      w_grant_n  = r_grant;
      w_idx_n    = r_idx;
      w_ptr_n    = r_ptr;
      w_term_n   = r_term;
      w_pend_v_n = r_pend_v;
      w_pend_t_n = r_pend_t;

      case (r_state)
         IDLE: begin
            w_count_n = '0;
            w_grant_n = '0;
            if (w_xfer) w_term_n = bus.cfg_term;
            if (w_pick_idle[c_IDX_W]) begin
               w_state_n = RUN;
               w_idx_n   = w_pick_idle[c_IDX_W-1:0];
               w_grant_n = c_ONE << w_pick_idle[c_IDX_W-1:0];
            end
         end
         RUN: begin
            if (w_tick) begin
               w_count_n = '0;
               w_ptr_n   = w_ptr_adv;
               // A value accepted during the tick cycle waits for the next boundary.
               if (r_pend_v) begin
                  w_term_n   = r_pend_t;
                  w_pend_v_n = 1'b0;
               end else if (w_xfer) begin
                  w_pend_t_n = bus.cfg_term;
                  w_pend_v_n = 1'b1;
               end
               if (w_pick_run[c_IDX_W]) begin
                  w_idx_n   = w_pick_run[c_IDX_W-1:0];
                  w_grant_n = c_ONE << w_pick_run[c_IDX_W-1:0];
               end else begin
                  w_state_n = IDLE;
                  w_grant_n = '0;
               end
            end else begin
               w_count_n = r_count + 1'b1;
               if (w_xfer) begin
                  w_pend_t_n = bus.cfg_term;
                  w_pend_v_n = 1'b1;
               end
            end
         end
         default: begin
            w_state_n = IDLE;
            w_grant_n = '0;
            w_count_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_grant  <= '0;
         r_idx    <= '0;
         r_ptr    <= '0;
         r_term   <= c_DEF_TERM;
         r_pend_v <= 1'b0;
         r_pend_t <= '0;
      end else begin
         r_state  <= w_state_n;
         r_count  <= w_count_n;
         r_grant  <= w_grant_n;
         r_idx    <= w_idx_n;
         r_ptr    <= w_ptr_n;
         r_term   <= w_term_n;
         r_pend_v <= w_pend_v_n;
         r_pend_t <= w_pend_t_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tick_slot_scheduler.sv
// ============================================================================
//  Module      : tb_tick_slot_scheduler
//  Description : Scoreboard bench for tick_slot_scheduler against a slice-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_slot_scheduler;

   localparam int c_N   = 4;
   localparam int c_W   = 32;
   localparam int c_DEF = 21;

   logic clk;
   logic rst;

   tick_slot_scheduler_if #(.N_REQ(c_N), .CNT_W(c_W)) sif ();

   tick_slot_scheduler #(
      .N_REQ(c_N), .CNT_W(c_W), .DEFAULT_TERM(c_DEF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           chk;
      logic [3:0]   grant;
      logic [31:0]  count;
      logic         tick;
      logic         busy;
      logic         rdy;
   } exp_t;

   exp_t        expq[$];
   logic [3:0]  tickq[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference model: who owns the counter, how far into the slice, what term.
   int          m_owner;
   logic [31:0] m_elapsed;
   logic [31:0] m_term;
   logic [31:0] m_pend[$];
   int          m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int first_from(input logic [3:0] r, input int p);
      for (int i = 0; i < c_N; i++)
         if (r[(p + i) % c_N]) return (p + i) % c_N;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_elapsed = 0;
      m_term    = c_DEF;
      m_pend.delete();
      m_ptr     = 0;
   endtask

   task automatic model_advance(input logic [3:0] r, input logic cv,
                                input logic [31:0] ct, input logic rs);
      bit xfer;
      xfer = cv && (m_pend.size() == 0);
      if (rs) begin
         model_reset();
      end else if (m_owner < 0) begin
         if (xfer) m_term = ct;
         m_owner   = first_from(r, m_ptr);
         m_elapsed = 0;
      end else if (m_elapsed >= m_term) begin
         m_ptr = (m_owner + 1) % c_N;
         if (m_pend.size() != 0) m_term = m_pend.pop_front();
         else if (xfer)          m_pend.push_back(ct);
         m_owner   = first_from(r, m_ptr);
         m_elapsed = 0;
      end else begin
         m_elapsed++;
         if (xfer) m_pend.push_back(ct);
      end
   endtask

   // One cycle: apply inputs, predict this cycle's outputs, then cross the edge.
   task automatic step(input logic [3:0] r, input logic cv,
                       input logic [31:0] ct, input logic rs);
      exp_t e;
      rst           = rs;
      sif.req       = r;
      sif.cfg_valid = cv;
      sif.cfg_term  = ct;
      e.chk   = !rs;
      e.grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e.count = m_elapsed;
      e.busy  = (m_owner >= 0);
      e.tick  = (m_owner >= 0) && (m_elapsed >= m_term);
      e.rdy   = (m_pend.size() == 0);
      expq.push_back(e);
      if (e.chk && e.tick) tickq.push_back(e.grant);
      @(posedge clk);
      model_advance(r, cv, ct, rs);
      #1;
   endtask

   task automatic run(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && m_owner >= 0; i++) step(4'b0000, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic cfg(input logic [3:0] r, input logic [31:0] t);
      step(r, 1'b1, t, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (e.chk) begin
            check("grant",     32'(sif.grant),     32'(e.grant));
            check("count",     sif.count,          e.count);
            check("tick",      32'(sif.tick),      32'(e.tick));
            check("busy",      32'(sif.busy),      32'(e.busy));
            check("cfg_ready", 32'(sif.cfg_ready), 32'(e.rdy));
            if (sif.tick === 1'b1) begin
               if (tickq.size() == 0) check("tick_unexpected", 32'd1, 32'd0);
               else                   check("tick_owner", 32'(sif.grant), 32'(tickq.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [3:0] r;
      rst           = 1'b1;
      sif.req       = '0;
      sif.cfg_valid = 1'b0;
      sif.cfg_term  = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Single requester, default term: back-to-back 22-cycle slices.
      run(4'b0000, 2);
      run(4'b0001, 50);
      drain();

      // Three requesters rotating with term 3.
      cfg(4'b0000, 32'd3);
      run(4'b1011, 30);
      drain();

      // Request dropped mid-slice: grant held until the tick.
      cfg(4'b0000, 32'd5);
      run(4'b0100, 2);
      run(4'b0000, 10);

      // Reconfigure during a slice: old term finishes, new one follows.
      cfg(4'b0000, 32'd21);
      run(4'b0001, 11);
      cfg(4'b0001, 32'd7);
      run(4'b0001, 40);
      drain();

      // Term 0: every cycle is a slice.
      cfg(4'b0000, 32'd0);
      run(4'b0011, 10);
      drain();

      // Config accepted on the IDLE->RUN edge.
      cfg(4'b0010, 32'd2);
      run(4'b0010, 8);
      drain();

      // Reset mid-slice, then a fresh request.
      cfg(4'b0000, 32'd21);
      run(4'b0001, 10);
      step(4'b0001, 1'b0, 32'd0, 1'b1);
      run(4'b1000, 30);
      drain();

      // Randomized traffic with small terms, occasional config and reset.
      r = 4'b0000;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) r = 4'($urandom);
         step(r, ($urandom_range(0, 7) == 0), 32'($urandom_range(0, 6)),
              ($urandom_range(0, 299) == 0));
      end
      run(4'b0000, 2);
      drain();
      run(4'b0000, 2);

      check("tick_queue_empty", 32'(tickq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
